mult_operand_sequencer: RTL and testbench
=========================================

# mult_operand_sequencer

Upstream stage and control sequencer for the sweep sequential multiplier datapath. Captures two signed DW-bit operands, splits each into a sign and a (DW-1)-bit magnitude, and drives the adder stage's `l_s`, `permit`, `rgstr1`, `rgstr2` inputs. `rgstr2` holds the multiplicand magnitude, shifted left one bit per permit cycle. Exports the product sign, which the downstream two's-complement correction stage consumes.

## Interface
- DW, from Pkg_Global (8): operand width; bit DW-1 is the sign.
- DW_2, from Pkg_Global (2*DW): product / `rgstr2` width.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; one clock, synchronous and active-low.
- start  in  1  request a new multiplication; sampled in IDLE and DONE only.
- multiplier  in  DW  signed operand A.
- multiplicand  in  DW  signed operand B.
- adder_done  in  1  `done` from the adder stage.
- l_s  out  1  clear pulse to the adder.
- permit  out  1  enables adder sweeping and holds its result.
- rgstr1  out  DW  multiplier magnitude, MSB forced 0.
- rgstr2  out  DW_2  zero-extended multiplicand magnitude, shifted left.
- sign  out  1  product sign: multiplier[DW-1] XOR multiplicand[DW-1].
- out_of_range  out  1  an operand equals -2^(DW-1).
- busy  out  1  state is LOAD or RUN.
- ready  out  1  state is DONE; adder product valid.

## Operation
- FSM states (in Pkg_Global): IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from state (Moore).
- IDLE:
  - All outputs 0.
  - start=1 → capture operands, go to LOAD.
- Capture (same edge):
  - Magnitude: x if x[DW-1]=0, else (~x+1). Truncate to DW-1 bits.
  - rgstr1 = {1'b0, |A|}; rgstr2 = zero-extended |B|.
  - sign = A[DW-1]^B[DW-1], except sign=0 when either operand is 0.
  - out_of_range = 1 if either operand is 100..0. That magnitude is truncated to 0, so the product is 0.
- LOAD: one cycle; l_s=1, permit=0, busy=1. Next state is always RUN.
- RUN:
  - permit=1, busy=1.
  - Each cycle with adder_done=0: rgstr2 <= rgstr2 << 1 (zero fill; bits shifted past DW_2-1 are dropped).
  - adder_done=1 → freeze rgstr2, go to DONE.
  - start is ignored.
- DONE:
  - permit=1 holds the adder product; ready=1.
  - rgstr1, rgstr2, sign, out_of_range are held.
  - start=1 → capture new operands, go to LOAD (ready drops next cycle).
  - Otherwise stay in DONE indefinitely.
- Reset asserted in any state, including mid-RUN: next edge → IDLE with all outputs 0. The adder stage is cleared by the same rst net.

## Timing
- start sampled high at edge k:
  - LOAD during cycle k+1 (l_s=1).
  - RUN from cycle k+2; the first permit cycle pairs adder count 0 with the unshifted rgstr2.
- Adder count reaches DW-1 in cycle k+DW+1. adder_done is seen at k+DW+2; DONE (ready=1) from cycle k+DW+3.
- Start-to-ready latency is DW+2 cycles after the sampling edge (10 for DW=8).
- rgstr2 in RUN cycle k+2+i equals |B|<<i, for i = 0..DW-1.
- start held continuously: restarts on each entry to DONE; ready is high for one cycle per product.
- start and adder_done in the same RUN cycle: adder_done wins (→ DONE); start is not latched.

## Structure
- Pkg_Global additions:
  - typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_e.
  - Reuse DW, DW_2, ONE, ZERO, BIT_ZERO, BIT_ONE.
  - Add MIN_NEG = {1'b1, {DW-1{1'b0}}}.
- One sub-module, `abs_value`: combinational magnitude plus is-min-negative flag. Instantiate it twice. The FSM, capture registers and shifter stay in the top.
- Top wrapper connects this block to the adder. The bench uses both together.

## Test plan
- DW=8, A=5, B=3:
  - rgstr1=0x05, rgstr2 sequence 0x0003, 0x0006, 0x000C, …; sign=0.
  - ready at k+10; adder product = 15.
- A=-5 (0xFB), B=3: rgstr1=0x05, sign=1, product magnitude 15.
- A=-6, B=-7: sign=0, product 42.
- A=0 with B=-9: sign=0, product 0.
- A=-128, B=3: out_of_range=1, product 0.
- start pulse in the middle of RUN: ignored; ready still at k+10.
- rst low for one edge at cycle k+5: next cycle all outputs 0, state IDLE; a new start gives a correct result at the normal latency.
- In DONE, hold for 20 cycles with start=0: ready, permit and product stable. Then start with A=7, B=9: ready drops next cycle; new ready after 10 cycles with product 63.

Source files
------------

// File: rtl/mult_operand_sequencer_pkg.sv
// mult_operand_sequencer_pkg: shared widths, constants and state type for the sweep multiplier front end.
//   DW       operand width, bit DW-1 is the sign
//   DW_2     product / shifted multiplicand width
//   MIN_NEG  the one operand value whose magnitude does not fit in DW-1 bits
package mult_operand_sequencer_pkg;

    localparam int DW   = 8;
    localparam int DW_2 = 2 * DW;

    localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] ZERO     = '0;
    localparam logic          BIT_ZERO = 1'b0;
    localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_e;

    function automatic logic [DW_2-1:0] zext_mag(input logic [DW-2:0] m);
        return {{(DW_2-DW+1){1'b0}}, m};
    endfunction

endpackage

// File: rtl/mult_operand_sequencer_abs.sv
// abs_value: combinational sign-magnitude split of one signed operand.
//   x        in   DW    signed operand
//   mag      out  DW-1  magnitude, truncated (MIN_NEG yields 0)
//   is_min   out  1     operand equals MIN_NEG
//   is_zero  out  1     operand equals 0
module abs_value
    import mult_operand_sequencer_pkg::*;
(
    input  logic [DW-1:0] x,
    output logic [DW-2:0] mag,
    output logic          is_min,
    output logic          is_zero
);

    // Only the low DW-1 bits of the two's-complement negation are kept,
    // so negating the low bits alone gives the same truncated magnitude.
    always_comb begin
        mag     = x[DW-1] ? (~x[DW-2:0] + ONE[DW-2:0]) : x[DW-2:0];
        is_min  = (x == MIN_NEG);
        is_zero = (x == ZERO);
    end

endmodule

// File: rtl/mult_operand_sequencer.sv
// mult_operand_sequencer: operand capture and control sequencer feeding the sweep adder stage.
//   clk           in   1     system clock
//   rst           in   1     synchronous active-low reset
//   start         in   1     begin a multiplication (honoured in IDLE and DONE)
//   multiplier    in   DW    signed operand A
//   multiplicand  in   DW    signed operand B
//   adder_done    in   1     adder stage has swept all multiplier bits
//   l_s           out  1     adder clear pulse
//   permit        out  1     adder sweep enable / result hold
//   rgstr1        out  DW    |A| with MSB 0
//   rgstr2        out  DW_2  |B| zero-extended, shifted left each sweep cycle
//   sign          out  1     product sign
//   out_of_range  out  1     an operand was MIN_NEG
//   busy          out  1     in LOAD or RUN
//   ready         out  1     in DONE, adder product valid
module mult_operand_sequencer
    import mult_operand_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   multiplier,
    input  logic [DW-1:0]   multiplicand,
    input  logic            adder_done,
    output logic            l_s,
    output logic            permit,
    output logic [DW-1:0]   rgstr1,
    output logic [DW_2-1:0] rgstr2,
    output logic            sign,
    output logic            out_of_range,
    output logic            busy,
    output logic            ready
);

    logic [DW-2:0] mag_a, mag_b;
    logic          min_a, min_b, zero_a, zero_b;

    abs_value u_abs_a (.x(multiplier),   .mag(mag_a), .is_min(min_a), .is_zero(zero_a));
    abs_value u_abs_b (.x(multiplicand), .mag(mag_b), .is_min(min_b), .is_zero(zero_b));

    seq_state_e      state_q, state_d;
    logic [DW-1:0]   rgstr1_q, rgstr1_d;
    logic [DW_2-1:0] rgstr2_q, rgstr2_d;
    logic            sign_q, sign_d;
    logic            oor_q, oor_d;
    logic            l_s_q, l_s_d;
    logic            permit_q, permit_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            capture;

    always_comb begin
        capture  = start && (state_q == IDLE || state_q == DONE);
        state_d  = (state_q == LOAD) ? RUN :
                   (state_q == RUN)  ? (adder_done ? DONE : RUN) :
                   capture           ? LOAD : state_q;
        rgstr1_d = capture ? {BIT_ZERO, mag_a} : rgstr1_q;
        // Shift stops on the cycle adder_done is seen, freezing the last sweep value.
        rgstr2_d = capture ? zext_mag(mag_b) :
                   (state_q == RUN && !adder_done) ? rgstr2_q << 1 : rgstr2_q;
        // A zero operand forces a positive zero product regardless of the other sign.
        sign_d   = capture ? (!zero_a && !zero_b && (multiplier[DW-1] ^ multiplicand[DW-1])) : sign_q;
        oor_d    = capture ? (min_a || min_b) : oor_q;
        // Outputs are decoded from the next state so they are registered yet aligned with state.
        l_s_d    = (state_d == LOAD);
        permit_d = (state_d == RUN) || (state_d == DONE);
        busy_d   = (state_d == LOAD) || (state_d == RUN);
        ready_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            rgstr1_q <= '0;
            rgstr2_q <= '0;
            sign_q   <= 1'b0;
            oor_q    <= 1'b0;
            l_s_q    <= 1'b0;
            permit_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rgstr1_q <= rgstr1_d;
            rgstr2_q <= rgstr2_d;
            sign_q   <= sign_d;
            oor_q    <= oor_d;
            l_s_q    <= l_s_d;
            permit_q <= permit_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign l_s          = l_s_q;
    assign permit       = permit_q;
    assign rgstr1       = rgstr1_q;
    assign rgstr2       = rgstr2_q;
    assign sign         = sign_q;
    assign out_of_range = oor_q;
    assign busy         = busy_q;
    assign ready        = ready_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// tb_mult_operand_sequencer: sequencer plus a behavioural sweep adder, checked by vector table, corner sequences and random operands.
module tb_mult_operand_sequencer;
    import mult_operand_sequencer_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [DW-1:0]   multiplier = '0;
    logic [DW-1:0]   multiplicand = '0;
    logic            adder_done;
    logic            l_s, permit, sign, out_of_range, busy, ready;
    logic [DW-1:0]   rgstr1;
    logic [DW_2-1:0] rgstr2;

    int n_checks = 0;
    int n_fail = 0;

    mult_operand_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .multiplier(multiplier), .multiplicand(multiplicand), .adder_done(adder_done),
        .l_s(l_s), .permit(permit), .rgstr1(rgstr1), .rgstr2(rgstr2),
        .sign(sign), .out_of_range(out_of_range), .busy(busy), .ready(ready)
    );

    always #5 clk = ~clk;

    // Sweep adder stage: one multiplier bit per permit cycle, done registered after bit DW-1.
    logic [2:0]      cnt;
    logic [DW_2-1:0] acc;
    always @(posedge clk) begin
        if (!rst || l_s) begin
            cnt <= '0;
            acc <= '0;
            adder_done <= 1'b0;
        end else if (permit && !adder_done) begin
            if (rgstr1[cnt]) acc <= acc + rgstr2;
            if (cnt == 3'(DW-1)) adder_done <= 1'b1;
            else cnt <= cnt + 3'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ref_mag(input logic [DW-1:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        return v % (1 << (DW-1));
    endfunction

    task automatic launch(input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        multiplier = a;
        multiplicand = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int r1, input int r2, input int sg, input int oor, input int prod);
        launch(a, b);
        check("load_ctl", 32'({l_s, busy, permit, ready}), 32'b1100);
        check("rgstr1", 32'(rgstr1), r1);
        check("sign", 32'(sign), sg);
        check("out_of_range", 32'(out_of_range), oor);
        for (int i = 0; i < DW; i++) begin
            @(negedge clk);
            check("run_rgstr2", 32'(rgstr2), (r2 << i) & 32'hffff);
            check("run_ctl", 32'({l_s, busy, permit, ready}), 32'b0110);
        end
        @(negedge clk);
        check("pre_ready", 32'(ready), 0);
        @(negedge clk);
        check("done_ctl", 32'({l_s, busy, permit, ready}), 32'b0011);
        check("product", 32'(acc), prod);
        check("rgstr2_frozen", 32'(rgstr2), (r2 << DW) & 32'hffff);
    endtask

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [7:0]    r1;
        logic [7:0]    r2;
        logic          sg;
        logic          oor;
        logic [15:0]   prod;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{a: 8'd5,    b: 8'd3,    r1: 8'd5,   r2: 8'd3,   sg: 1'b0, oor: 1'b0, prod: 16'd15};
        vecs[1] = '{a: 8'hFB,   b: 8'd3,    r1: 8'd5,   r2: 8'd3,   sg: 1'b1, oor: 1'b0, prod: 16'd15};
        vecs[2] = '{a: 8'hFA,   b: 8'hF9,   r1: 8'd6,   r2: 8'd7,   sg: 1'b0, oor: 1'b0, prod: 16'd42};
        vecs[3] = '{a: 8'h00,   b: 8'hF7,   r1: 8'd0,   r2: 8'd9,   sg: 1'b0, oor: 1'b0, prod: 16'd0};
        vecs[4] = '{a: 8'h80,   b: 8'd3,    r1: 8'd0,   r2: 8'd3,   sg: 1'b1, oor: 1'b1, prod: 16'd0};
        vecs[5] = '{a: 8'd5,    b: 8'h80,   r1: 8'd5,   r2: 8'd0,   sg: 1'b1, oor: 1'b1, prod: 16'd0};
        vecs[6] = '{a: 8'd127,  b: 8'd127,  r1: 8'd127, r2: 8'd127, sg: 1'b0, oor: 1'b0, prod: 16'd16129};
        vecs[7] = '{a: 8'hFF,   b: 8'd1,    r1: 8'd1,   r2: 8'd1,   sg: 1'b1, oor: 1'b0, prod: 16'd1};

        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({l_s, permit, busy, ready, sign, out_of_range, rgstr1, rgstr2}), 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", 32'({l_s, permit, busy, ready, sign, out_of_range, rgstr1, rgstr2}), 0);

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, int'(vecs[i].r1), int'(vecs[i].r2),
                   int'(vecs[i].sg), int'(vecs[i].oor), int'(vecs[i].prod));

        // start pulse mid-RUN is ignored
        launch(8'd5, 8'd3);
        repeat (3) @(negedge clk);
        multiplier = 8'd7;
        multiplicand = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("midrun_pre_ready", 32'(ready), 0);
        @(negedge clk);
        check("midrun_ready", 32'(ready), 1);
        check("midrun_product", 32'(acc), 15);
        check("midrun_rgstr1", 32'(rgstr1), 5);

        // reset in the middle of RUN
        launch(8'd6, 8'd5);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrun_reset_outputs", 32'({l_s, permit, busy, ready, sign, out_of_range, rgstr1, rgstr2}), 0);
        check("midrun_reset_adder", 32'(acc), 0);
        rst = 1'b1;
        run_op(8'd6, 8'd5, 6, 5, 0, 0, 30);

        // DONE holds indefinitely, then restarts
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("done_hold_ctl", 32'({busy, permit, ready}), 32'b011);
            check("done_hold_product", 32'(acc), 30);
        end
        run_op(8'd7, 8'd9, 7, 9, 0, 0, 63);

        // start and adder_done in the same RUN cycle: DONE wins, start not latched
        launch(8'd2, 8'd3);
        repeat (9) @(negedge clk);
        check("same_cycle_adder_done", 32'({busy, adder_done}), 32'b11);
        multiplier = 8'd11;
        multiplicand = 8'd13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("same_cycle_ready", 32'(ready), 1);
        check("same_cycle_product", 32'(acc), 6);
        check("same_cycle_rgstr1", 32'(rgstr1), 2);
        @(negedge clk);
        check("same_cycle_stays_done", 32'({busy, ready}), 32'b01);

        // start held high: one ready cycle per product, restart every 11 cycles
        @(negedge clk);
        multiplier = 8'd3;
        multiplicand = 8'd4;
        start = 1'b1;
        for (int n = 0; n < 44; n++) begin
            @(negedge clk);
            if (n >= 10 && (n - 10) % 11 == 0) begin
                check("held_start_ready", 32'(ready), 1);
                check("held_start_product", 32'(acc), 12);
            end else begin
                check("held_start_not_ready", 32'(ready), 0);
            end
        end
        start = 1'b0;

        // random operands against the arithmetic model
        for (int t = 0; t < 25; t++) begin
            logic [DW-1:0] a, b;
            int va, vb, ea, eb;
            a = DW'($urandom);
            b = DW'($urandom);
            if (t == 0) a = 8'h80;
            if (t == 1) b = 8'h00;
            va = int'($signed(a));
            vb = int'($signed(b));
            ea = ref_mag(a);
            eb = ref_mag(b);
            run_op(a, b, ea, eb,
                   (va != 0 && vb != 0 && ((va < 0) != (vb < 0))) ? 1 : 0,
                   (va == -128 || vb == -128) ? 1 : 0,
                   ea * eb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
